pc_sequencer: RTL and testbench

- Parametrised, clocked program-counter unit; next generation of the datapath's PC block.
- Holds the architectural PC in a real register with configurable width, step and reset vector.
- Supports hold, sequential increment, absolute jump and PC-relative branch.
- Adds call/return through an internal return-address stack (RAS) and a stall enable.
- Sits between control-unit PS decode and instruction-memory address input.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_return_stack.sv | 46 ++++
 rtl/pc_sequencer.sv | 78 +++++++
 tb/tb_pc_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: operation select width
// and the PS encodings decoded by the control unit.
package pc_pkg;

    localparam int PS_W = 3;

    localparam logic [PS_W-1:0] PS_HOLD   = 3'b000;
    localparam logic [PS_W-1:0] PS_INC    = 3'b001;
    localparam logic [PS_W-1:0] PS_JUMP   = 3'b010;
    localparam logic [PS_W-1:0] PS_BRANCH = 3'b011;
    localparam logic [PS_W-1:0] PS_CALL   = 3'b100;
    localparam logic [PS_W-1:0] PS_RET    = 3'b101;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack. Push on full and pop on empty are ignored here;
// the caller is responsible for flagging them.
module pc_return_stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    count;
    logic [CW-1:0]    top;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top      = count - CW'(1);
    assign data_out = empty ? '0 : mem[top[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    // Entries need no reset: they are only read below the live count.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, next-PC selection, call/return through an
// internal return-address stack, and a sticky stack-error flag.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                WIDTH        = 64,
    parameter logic [WIDTH-1:0]  STEP         = WIDTH'(4),
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PS_W-1:0]  PS,
    input  logic [WIDTH-1:0] PC_IN,
    output logic [WIDTH-1:0] PC_OUT,
    output logic [WIDTH-1:0] PC_SEQ,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;
    logic             push;
    logic             pop;
    logic             overflow;
    logic             underflow;

    assign PC_OUT = pc_q;
    assign PC_SEQ = pc_q + STEP;

    // Stack side effects only happen when the PC itself is allowed to move.
    assign push      = en && (PS == PS_CALL) && !ras_full;
    assign pop       = en && (PS == PS_RET)  && !ras_empty;
    assign overflow  = en && (PS == PS_CALL) && ras_full;
    assign underflow = en && (PS == PS_RET)  && ras_empty;

    always_comb begin
        pc_next = pc_q;
        case (PS)
            PS_INC:    pc_next = pc_q + STEP;
            PS_JUMP:   pc_next = PC_IN;
            PS_BRANCH: pc_next = pc_q + PC_IN;
            PS_CALL:   pc_next = PC_IN;
            PS_RET:    pc_next = ras_empty ? (pc_q + STEP) : ras_top;
            default:   pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VECTOR;
            ras_err <= 1'b0;
        end else if (en) begin
            pc_q <= pc_next;
            if (overflow || underflow) begin
                ras_err <= 1'b1;
            end
        end
    end

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (PC_SEQ),
        .data_out (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with constant expectations plus a
// randomized run checked against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int W = 64;
    localparam int DEPTH = 4;
    localparam logic [W-1:0] STEP = 64'd4;
    localparam logic [W-1:0] RV = 64'd0;

    logic         clk;
    logic         reset;
    logic         en;
    logic [2:0]   PS;
    logic [W-1:0] PC_IN;
    logic [W-1:0] PC_OUT;
    logic [W-1:0] PC_SEQ;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_err;

    int n_cmp = 0;
    int n_fail = 0;

    logic [W-1:0] m_pc;
    logic [W-1:0] exp_q[$];
    logic         m_err;

    pc_sequencer #(
        .WIDTH(W), .STEP(STEP), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .PS(PS), .PC_IN(PC_IN),
        .PC_OUT(PC_OUT), .PC_SEQ(PC_SEQ),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = RV;
        exp_q.delete();
        m_err = 1'b0;
    endtask

    // Reference model: the architectural effect of one accepted operation.
    task automatic model_op(input logic e, input logic [2:0] ps, input logic [W-1:0] in);
        if (!e) return;
        case (ps)
            3'd1: m_pc = m_pc + STEP;
            3'd2: m_pc = in;
            3'd3: m_pc = m_pc + in;
            3'd4: begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_pc + STEP);
                else m_err = 1'b1;
                m_pc = in;
            end
            3'd5: begin
                if (exp_q.size() > 0) m_pc = exp_q.pop_back();
                else begin
                    m_pc = m_pc + STEP;
                    m_err = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    // driver: inputs change 1 time unit after the edge, outputs sampled there too
    task automatic op(input logic e, input logic [2:0] ps, input logic [W-1:0] in);
        en = e;
        PS = ps;
        PC_IN = in;
        @(posedge clk);
        #1;
        model_op(e, ps, in);
    endtask

    task automatic do_reset();
        en = 1'b0;
        PS = 3'd0;
        PC_IN = '0;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        op(1'b1, 3'd2, 64'h777);
        op(1'b1, 3'd4, 64'h900);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (PC_OUT !== RV) begin
            n_fail++;
            $display("FAIL reset_pc: got %h expected %h", PC_OUT, RV);
        end
        n_cmp++;
        if ({ras_empty, ras_full, ras_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 100", {ras_empty, ras_full, ras_err});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_inc();
        for (int i = 1; i <= 3; i++) begin
            op(1'b1, 3'd1, '0);
            n_cmp++;
            if (PC_OUT !== 64'(4 * i)) begin
                n_fail++;
                $display("FAIL inc_%0d: got %h expected %h", i, PC_OUT, 64'(4 * i));
            end
        end
        n_cmp++;
        if (PC_SEQ !== 64'd16) begin
            n_fail++;
            $display("FAIL inc_seq: got %h expected %h", PC_SEQ, 64'd16);
        end
    endtask

    task automatic test_stall();
        op(1'b1, 3'd2, 64'h100);
        op(1'b0, 3'd2, 64'h500);
        n_cmp++;
        if (PC_OUT !== 64'h100) begin
            n_fail++;
            $display("FAIL stall_jump: got %h expected %h", PC_OUT, 64'h100);
        end
        op(1'b0, 3'd4, 64'h600);
        n_cmp++;
        if (PC_OUT !== 64'h100 || ras_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_call: got pc %h empty %b expected 100 1", PC_OUT, ras_empty);
        end
        op(1'b1, 3'd2, 64'h500);
        n_cmp++;
        if (PC_OUT !== 64'h500) begin
            n_fail++;
            $display("FAIL stall_release: got %h expected %h", PC_OUT, 64'h500);
        end
    endtask

    task automatic test_branch_wrap();
        op(1'b1, 3'd2, 64'h10);
        op(1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFF0);
        n_cmp++;
        if (PC_OUT !== 64'h0) begin
            n_fail++;
            $display("FAIL branch_neg: got %h expected 0", PC_OUT);
        end
        op(1'b1, 3'd3, 64'h123);
        n_cmp++;
        if (PC_OUT !== 64'h123) begin
            n_fail++;
            $display("FAIL branch_pos: got %h expected 123", PC_OUT);
        end
        op(1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC);
        n_cmp++;
        if (PC_SEQ !== 64'h0) begin
            n_fail++;
            $display("FAIL seq_wrap: got %h expected 0", PC_SEQ);
        end
        op(1'b1, 3'd1, '0);
        n_cmp++;
        if (PC_OUT !== 64'h0) begin
            n_fail++;
            $display("FAIL inc_wrap: got %h expected 0", PC_OUT);
        end
    endtask

    task automatic test_nested_call();
        logic [W-1:0] tgt [4];
        logic [W-1:0] exp_pc [4];
        logic [2:0]   ops [4];
        tgt = '{64'h200, 64'h300, 64'h0, 64'h0};
        exp_pc = '{64'h200, 64'h300, 64'h204, 64'h44};
        ops = '{3'd4, 3'd4, 3'd5, 3'd5};
        do_reset();
        op(1'b1, 3'd2, 64'h40);
        for (int i = 0; i < 4; i++) begin
            op(1'b1, ops[i], tgt[i]);
            n_cmp++;
            if (PC_OUT !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL nested_%0d: got %h expected %h", i, PC_OUT, exp_pc[i]);
            end
        end
        n_cmp++;
        if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            n_fail++;
            $display("FAIL nested_flags: got empty %b err %b expected 1 0", ras_empty, ras_err);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] ret_pc [4];
        ret_pc = '{64'h3004, 64'h2004, 64'h1004, 64'h44};
        do_reset();
        op(1'b1, 3'd2, 64'h40);
        for (int i = 1; i <= 5; i++) begin
            op(1'b1, 3'd4, 64'(i * 'h1000));
            if (i == 3 || i == 4) begin
                n_cmp++;
                if (ras_full !== (i == 4)) begin
                    n_fail++;
                    $display("FAIL ovf_full_%0d: got %b expected %b", i, ras_full, (i == 4));
                end
            end
        end
        n_cmp++;
        if (PC_OUT !== 64'h5000 || ras_err !== 1'b1 || ras_full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_fifth: got pc %h err %b full %b expected 5000 1 1",
                     PC_OUT, ras_err, ras_full);
        end
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 3'd5, '0);
            n_cmp++;
            if (PC_OUT !== ret_pc[i]) begin
                n_fail++;
                $display("FAIL ovf_ret_%0d: got %h expected %h", i, PC_OUT, ret_pc[i]);
            end
        end
        n_cmp++;
        if (ras_empty !== 1'b1 || ras_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_end: got empty %b err %b expected 1 1", ras_empty, ras_err);
        end
    endtask

    task automatic test_underflow_reset();
        do_reset();
        op(1'b1, 3'd2, 64'h80);
        op(1'b1, 3'd5, '0);
        n_cmp++;
        if (PC_OUT !== 64'h84 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: got pc %h err %b empty %b expected 84 1 1",
                     PC_OUT, ras_err, ras_empty);
        end
        op(1'b1, 3'd6, 64'hABC);
        op(1'b1, 3'd7, 64'hDEF);
        n_cmp++;
        if (PC_OUT !== 64'h84 || ras_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_hold: got pc %h err %b expected 84 1", PC_OUT, ras_err);
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (ras_err !== 1'b0 || PC_OUT !== RV) begin
            n_fail++;
            $display("FAIL reset_clears: got pc %h err %b expected %h 0", PC_OUT, ras_err, RV);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic         e;
        logic [2:0]   ps;
        logic [W-1:0] in;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 9) < 8);
            ps = 3'($urandom_range(0, 7));
            if (ps == 3'd3) in = 64'($signed($urandom_range(0, 511)) - 256);
            else in = {$urandom(), $urandom()};
            op(e, ps, in);
            n_cmp++;
            if (PC_OUT !== m_pc || PC_SEQ !== m_pc + STEP || ras_err !== m_err ||
                ras_empty !== (exp_q.size() == 0) || ras_full !== (exp_q.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL rand_%0d: got pc %h seq %h e/f/err %b%b%b expected pc %h depth %0d err %b",
                         i, PC_OUT, PC_SEQ, ras_empty, ras_full, ras_err, m_pc, exp_q.size(), m_err);
            end
            if (i % 100 == 99) do_reset();
        end
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b0;
        PS = 3'd0;
        PC_IN = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_inc();
        test_stall();
        test_branch_wrap();
        test_nested_call();
        test_overflow();
        test_underflow_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
